alu_pipe_stage: RTL and testbench

//   Registered execution stage wrapped around the 4-bit ALU datapath. It accepts

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 57 +++++
 rtl/alu_pipe_stage.sv | 136 +++++++++++++
 tb/tb_alu_pipe_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage.
//   OP_*          3-bit op codes accepted on in_op
//   ALU_W         default operand/result width
//   alu_result_t  packed {res, car, of} bundle at the default width
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_NE  = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] res;
        logic             car;
        logic             of;
    } alu_result_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
//   a, b  operands (WIDTH)
//   op    op code (alu_pkg OP_*)
//   res   result (WIDTH); compare ops return a zero-extended 0/1
//   car   carry out, add/sub only
//   of    signed overflow, add/sub only
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             car,
    output logic             of
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] dif_s;
    logic           lt_s;
    logic           ne_s;

    // Subtraction is a + ~b + 1 so car is the "no borrow" indication.
    assign sum_s = {1'b0, a} + {1'b0, b};
    assign dif_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign lt_s  = ($signed(a) < $signed(b));
    assign ne_s  = (a != b);

    // Select result and flags for the requested op.
    always_comb begin
        res = {WIDTH{1'b0}};
        car = 1'b0;
        of  = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum_s[WIDTH-1:0];
                car = sum_s[WIDTH];
                of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = dif_s[WIDTH-1:0];
                car = dif_s[WIDTH];
                of  = (a[WIDTH-1] != b[WIDTH-1]) && (dif_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  res = ~a;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_LT:   res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_NE:   res = {{(WIDTH-1){1'b0}}, ne_s};
            default: res = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_pipe_stage.sv
// Two-register ALU execution stage with valid/ready on both sides.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_a, in_b, in_op sampled on transfer
//   out_valid/out_ready   result handshake; out_res/out_car/out_of held while stalled
//   of_sticky, clr_sticky sticky overflow of delivered results, synchronous clear
//   op_count              delivered-result counter, wraps
// S1 holds the operands, alu_core evaluates between S1 and S2, S2 drives the outputs.
module alu_pipe_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_car,
    output logic             out_of,
    output logic             of_sticky,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] res_r;
    logic             car_r;
    logic             of_r;
    logic             sticky_r;
    logic [CNT_W-1:0] count_r;

    logic [WIDTH-1:0] core_res_s;
    logic             core_car_s;
    logic             core_of_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             s2_load_s;

    // S2 takes S1 whenever it is empty or being drained this edge.
    assign out_xfer_s = s2_valid_r & out_ready;
    assign s2_load_s  = s1_valid_r & (~s2_valid_r | out_ready);
    // Depends on out_ready but never on in_valid.
    assign in_ready   = ~s1_valid_r | ~s2_valid_r | out_ready;
    assign in_xfer_s  = in_valid & in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a   (s1_a_r),
        .b   (s1_b_r),
        .op  (s1_op_r),
        .res (core_res_s),
        .car (core_car_s),
        .of  (core_of_s)
    );

    // Operand register S1: load on input transfer, empty when handed to S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 3'b000;
        end else begin
            if (in_xfer_s) begin
                s1_valid_r <= 1'b1;
                s1_a_r     <= in_a;
                s1_b_r     <= in_b;
                s1_op_r    <= in_op;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end
        end
    end

    // Result register S2: data only changes on a load, so a stalled result holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            res_r      <= {WIDTH{1'b0}};
            car_r      <= 1'b0;
            of_r       <= 1'b0;
        end else begin
            if (s2_load_s) begin
                s2_valid_r <= 1'b1;
                res_r      <= core_res_s;
                car_r      <= core_car_s;
                of_r       <= core_of_s;
            end else if (out_xfer_s) begin
                s2_valid_r <= 1'b0;
            end
        end
    end

    // Sticky overflow: a delivered overflow beats a same-edge clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else begin
            if (out_xfer_s && of_r) begin
                sticky_r <= 1'b1;
            end else if (clr_sticky) begin
                sticky_r <= 1'b0;
            end
        end
    end

    // Delivered-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (out_xfer_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign out_res   = res_r;
    assign out_car   = car_r;
    assign out_of    = of_r;
    assign of_sticky = sticky_r;
    assign op_count  = count_r;

endmodule

// File: tb/tb_alu_pipe_stage.sv
// Self-checking bench for alu_pipe_stage: directed cases, backpressure,
// reset mid-stream, a 300-op stream and a random-backpressure phase, all
// compared every cycle against a transaction-level model (queue of pending results).
module tb_alu_pipe_stage;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_car;
    logic             out_of;
    logic             of_sticky;
    logic             clr_sticky;
    logic [CNT_W-1:0] op_count;

    alu_pipe_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_car    (out_car),
        .out_of     (out_of),
        .of_sticky  (of_sticky),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_result_t r;
        int          stamp;
    } pend_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    pend_t exp_q[$];
    logic  model_sticky = 1'b0;
    int    model_count = 0;
    bit    checking = 1'b0;
    bit    rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from plain integer arithmetic on the 4-bit values.
    function automatic alu_result_t ref_alu(input int a, input int b, input logic [2:0] op);
        alu_result_t x;
        int sa, sb, r;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        x.res = 4'h0;
        x.car = 1'b0;
        x.of  = 1'b0;
        case (op)
            OP_ADD: begin
                r = a + b;
                x.res = 4'(r % 16);
                x.car = (r > 15);
                x.of  = (sa + sb > 7) || (sa + sb < -8);
            end
            OP_SUB: begin
                r = a - b + 16;
                x.res = 4'(r % 16);
                x.car = (a >= b);
                x.of  = (sa - sb > 7) || (sa - sb < -8);
            end
            OP_NOT:  x.res = 4'(15 - a);
            OP_AND:  x.res = 4'(a & b);
            OP_OR:   x.res = 4'(a | b);
            OP_XOR:  x.res = 4'(a ^ b);
            OP_LT:   x.res = (sa < sb) ? 4'h1 : 4'h0;
            OP_NE:   x.res = (a != b) ? 4'h1 : 4'h0;
            default: x.res = 4'h0;
        endcase
        return x;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Compare process: check outputs against the model, then advance the model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            model_sticky = 1'b0;
            model_count  = 0;
        end else if (checking) begin
            logic ev;
            logic hit_of;
            ev = (exp_q.size() > 0) && (exp_q[0].stamp + 1 <= cyc);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            chk("op_count", op_count, 32'(model_count % 256));
            chk("of_sticky", of_sticky, model_sticky);
            if (ev) begin
                chk("out_res", out_res, exp_q[0].r.res);
                chk("out_car", out_car, exp_q[0].r.car);
                chk("out_of", out_of, exp_q[0].r.of);
            end
            hit_of = 1'b0;
            if (ev && out_ready) begin
                hit_of = exp_q[0].r.of;
                model_count++;
                void'(exp_q.pop_front());
            end
            if (hit_of) model_sticky = 1'b1;
            else if (clr_sticky) model_sticky = 1'b0;
            if (in_valid && in_ready) begin
                pend_t p;
                p.r     = ref_alu(int'(in_a), int'(in_b), in_op);
                p.stamp = cyc + 1;
                exp_q.push_back(p);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int t;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                chk("send timeout in_ready", in_ready, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [3:0] r, input logic c, input logic o);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            t++;
            @(negedge clk);
        end
        chk({name, " valid"}, out_valid, 1'b1);
        chk({name, " res"}, out_res, r);
        chk({name, " car"}, out_car, c);
        chk({name, " of"}, out_of, o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        alu_result_t m;
        int t0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 4'h0;
        in_b = 4'h0;
        in_op = 3'b000;
        out_ready = 1'b1;
        clr_sticky = 1'b0;

        // Pin the model with hand-computed values.
        m = ref_alu(7, 1, OP_ADD);   chk("model add 7+1", m, {4'h8, 1'b0, 1'b1});
        m = ref_alu(15, 1, OP_ADD);  chk("model add F+1", m, {4'h0, 1'b1, 1'b0});
        m = ref_alu(3, 5, OP_SUB);   chk("model sub 3-5", m, {4'hE, 1'b0, 1'b0});
        m = ref_alu(8, 1, OP_SUB);   chk("model sub 8-1", m, {4'h7, 1'b1, 1'b1});
        m = ref_alu(8, 1, OP_LT);    chk("model lt 8,1", m, {4'h1, 1'b0, 1'b0});
        m = ref_alu(5, 5, OP_NE);    chk("model ne 5,5", m, {4'h0, 1'b0, 1'b0});

        idle(2);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_res", out_res, 4'h0);
        chk("reset op_count", op_count, 8'h00);
        chk("reset of_sticky", of_sticky, 1'b0);
        rst = 1'b0;
        checking = 1'b1;
        idle(1);

        // Arithmetic and compare cases with literal expectations.
        send(4'h7, 4'h1, OP_ADD);
        wait_out("add 7+1", 4'h8, 1'b0, 1'b1);
        chk("sticky after 7+1", of_sticky, 1'b1);
        send(4'hF, 4'h1, OP_ADD);
        wait_out("add F+1", 4'h0, 1'b1, 1'b0);
        send(4'h3, 4'h5, OP_SUB);
        wait_out("sub 3-5", 4'hE, 1'b0, 1'b0);
        send(4'h8, 4'h1, OP_LT);
        wait_out("lt 8,1", 4'h1, 1'b0, 1'b0);
        send(4'h5, 4'h5, OP_NE);
        wait_out("ne 5,5", 4'h0, 1'b0, 1'b0);

        // Clear while an overflow result transfers: set wins, then clear alone.
        send(4'h8, 4'h1, OP_SUB);
        clr_sticky = 1'b1;
        wait_out("sub 8-1", 4'h7, 1'b1, 1'b1);
        chk("sticky set beats clr", of_sticky, 1'b1);
        idle(1);
        chk("sticky clr alone", of_sticky, 1'b0);
        clr_sticky = 1'b0;

        // Backpressure: two accepted, third held off, results in order.
        out_ready = 1'b0;
        send(4'h1, 4'h2, OP_ADD);
        send(4'h3, 4'h4, OP_SUB);
        in_valid = 1'b1;
        in_a = 4'h5;
        in_b = 4'h6;
        in_op = OP_XOR;
        repeat (3) begin
            @(negedge clk);
            chk("bp in_ready", in_ready, 1'b0);
            chk("bp out_res", out_res, 4'h3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(4);

        // Deliver an overflow so the reset below has a set sticky to clear.
        send(4'h7, 4'h1, OP_ADD);
        idle(3);

        // Reset mid-stream with two ops in flight.
        out_ready = 1'b0;
        send(4'h2, 4'h3, OP_ADD);
        send(4'h4, 4'h5, OP_OR);
        chk("pre-reset sticky", of_sticky, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 1'b0);
        chk("async rst op_count", op_count, 8'h00);
        chk("async rst of_sticky", of_sticky, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);

        // 300 back-to-back random ops at full throughput.
        t0 = cyc;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end
        chk("stream cycles", cyc - t0, 300);
        idle(3);
        chk("stream op_count", op_count, 8'd44);

        // Random backpressure, gaps and clears.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            clr_sticky = ($urandom_range(0, 7) == 0);
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        clr_sticky = 1'b0;
        rand_rdy = 1'b0;
        #1;
        out_ready = 1'b1;
        idle(6);
        chk("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
